// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers received bytes in a FWFT FIFO behind a valid/ready
// stream, counts framing errors, flags overrun. Optional timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int Depth        = 8,
  parameter int Oversample   = 16,
  parameter int TimeoutChars = 4
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     enable,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic [7:0]               outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(Depth):0]   count,
  output logic                     overrun,
  output logic [7:0]               errCount,
  input  logic                     clearErr,
  output logic                     timeout
);

  localparam int PTR_W = $clog2(Depth);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_T  = TimeoutChars * 10 * Oversample;
  localparam int TO_W  = $clog2(TO_T + 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_FLUSH  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [7:0]         mem [Depth];

  logic               live;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [CNT_W-1:0]   remain;
  logic [PTR_W-1:0]   rd_next;

  always_comb begin
    live    = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    full    = (count_q == CNT_W'(Depth));
    pop     = live && (count_q != '0) && outReady;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    push    = live && rxDone && (!full || pop);
    drop    = live && rxDone && full && !pop;
    remain  = pop ? (count_q - CNT_W'(1)) : count_q;
    rd_next = rd_ptr_q + PTR_W'(pop);
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_next;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (state_q == S_FLUSH) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Head register: refreshed only when the old head leaves or the FIFO was empty.
  always_comb begin
    out_data_d = out_data_q;
    if (live && (pop || (count_q == '0))) begin
      if (remain != '0) begin
        out_data_d = mem[rd_next];
      end else if (push) begin
        out_data_d = rxData;
      end
    end
    out_valid_d = (count_d != '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:    state_d = enable ? S_IDLE : S_OFF;
      S_IDLE:   state_d = !enable ? S_FLUSH : ((count_d != '0) ? S_ACTIVE : S_IDLE);
      S_ACTIVE: state_d = !enable ? S_FLUSH : ((count_d == '0) ? S_IDLE : S_ACTIVE);
      S_FLUSH:  state_d = S_OFF;
      default:  state_d = S_OFF;
    endcase
  end

  always_comb begin
    overrun_d   = overrun_q | drop;
    err_count_d = err_count_q;
    if (live && rxErr && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
    if (clearErr) begin
      overrun_d   = 1'b0;
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rxData;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_OFF;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  // Counts idle cycles with data parked in the FIFO; saturates at the threshold.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q != S_ACTIVE) || push || pop || (count_q == '0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_W'(TO_T)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    timeout_d = (to_cnt_d == TO_W'(TO_T));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign errCount = err_count_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: vector table, directed corner sequences, and a random run
// against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int T_TO  = 4 * 10 * 16;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nReset;
  logic       enable, rxDone, rxErr, outReady, clearErr;
  logic [7:0] rxData;
  logic [7:0] outData;
  logic       outValid, overrun, timeout;
  logic [3:0] count;
  logic [7:0] errCount;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(.Depth(DEPTH), .Oversample(16), .TimeoutChars(4)) dut (
    .clk(clk), .nReset(nReset), .enable(enable), .rxData(rxData), .rxDone(rxDone),
    .rxErr(rxErr), .outData(outData), .outValid(outValid), .outReady(outReady),
    .count(count), .overrun(overrun), .errCount(errCount), .clearErr(clearErr),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       dn;
    logic [7:0] d;
    logic       er;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    int         ec;
    int         ee;
  } vec_t;

  vec_t tbl[9];

  // Reference model state
  logic [7:0] mq[$];
  bit         m_on, m_fl;
  logic       m_ovr;
  int         m_err, m_idle;
  logic [7:0] m_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    enable = 1'b1; rxDone = 1'b0; rxData = 8'h00; rxErr = 1'b0;
    outReady = 1'b0; clearErr = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    enable = 1'b0;
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    rxDone = 1'b1; rxData = b;
    tick();
    rxDone = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_on = 0; m_fl = 0; m_ovr = 1'b0; m_err = 0; m_idle = 0; m_head = 8'h00;
  endtask

  // Applies the current inputs for one clock, following the behavioural rules.
  task automatic model_step();
    int  sz;
    bit  popped, pushed, set_ovr, inc;
    popped = 0; pushed = 0; set_ovr = 0; inc = 0;
    if (m_fl) begin
      mq.delete(); m_fl = 0; m_on = 0; m_idle = 0;
    end else if (!m_on) begin
      if (enable) m_on = 1;
    end else begin
      sz = mq.size();
      popped = (sz > 0) && outReady;
      if (popped) void'(mq.pop_front());
      if (rxDone) begin
        if (sz < DEPTH || popped) begin
          mq.push_back(rxData); pushed = 1;
        end else set_ovr = 1;
      end
      inc = rxErr;
      if (pushed || popped || sz == 0) m_idle = 0;
      else if (m_idle < T_TO) m_idle++;
      if (!enable) m_fl = 1;
    end
    if (clearErr) begin
      m_ovr = 1'b0; m_err = 0;
    end else begin
      if (set_ovr) m_ovr = 1'b1;
      if (inc && m_err < 255) m_err++;
    end
    if (mq.size() > 0) m_head = mq[0];
  endtask

  initial begin
    logic [7:0] exp_b [8];
    logic [31:0] exp_v;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 0};
    tbl[2] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 2, 0};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1, 0};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1};
    tbl[6] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1, 2};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1, 0};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 0, 0};

    do_reset();
    chk("rst_valid", outValid, 0);
    chk("rst_data", outData, 0);
    chk("rst_count", count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_err", errCount, 0);
    chk("rst_to", timeout, 0);

    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en; rxDone = tbl[i].dn; rxData = tbl[i].d; rxErr = tbl[i].er;
      outReady = tbl[i].rdy; clearErr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_valid", i), outValid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), outData, tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      chk($sformatf("tbl%0d_err", i), errCount, tbl[i].ee);
    end
    idle_in();

    // Overflow: nine bytes into eight slots
    for (int i = 0; i < 9; i++) push(8'(i));
    chk("ovf_count", count, 8);
    chk("ovf_ovr", overrun, 1);
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_rd%0d", i), outData, i);
      tick();
    end
    outReady = 1'b0;
    chk("ovf_empty", outValid, 0);
    clearErr = 1'b1; tick(); clearErr = 1'b0;
    chk("ovf_clear", overrun, 0);

    // Full with same-cycle pop
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    outReady = 1'b1; rxDone = 1'b1; rxData = 8'h55;
    tick();
    rxDone = 1'b0;
    chk("fp_count", count, 8);
    chk("fp_ovr", overrun, 0);
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h11 + 8'(i);
    exp_b[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fp_rd%0d", i), outData, exp_b[i]);
      tick();
    end
    outReady = 1'b0;
    chk("fp_empty", count, 0);

    // Error counter saturation
    rxErr = 1'b1;
    repeat (257) tick();
    chk("err_sat", errCount, 255);
    rxDone = 1'b1; rxData = 8'h11;
    tick();
    rxErr = 1'b0; rxDone = 1'b0;
    chk("errdn_count", count, 1);
    chk("errdn_data", outData, 8'h11);
    chk("errdn_err", errCount, 255);

    // Flush with data buffered
    push(8'h21); push(8'h22);
    chk("fl_pre", count, 3);
    enable = 1'b0;
    tick();
    tick();
    chk("fl_count", count, 0);
    chk("fl_valid", outValid, 0);
    chk("fl_err_held", errCount, 255);
    rxDone = 1'b1; rxData = 8'h66;
    tick();
    chk("off_ignore", count, 0);
    enable = 1'b1;
    tick();
    chk("off_en_ignore", count, 0);
    push(8'h99);
    chk("on_push_count", count, 1);
    chk("on_push_data", outData, 8'h99);
    push(8'h9A);

    // Asynchronous reset away from a clock edge
    #2 nReset = 1'b0;
    #1;
    chk("ar_valid", outValid, 0);
    chk("ar_data", outData, 0);
    chk("ar_count", count, 0);
    chk("ar_err", errCount, 0);
    chk("ar_to", timeout, 0);
    tick();
    nReset = 1'b1;
    idle_in();

    // Character timeout
    tick();
    push(8'h77);
    for (int k = 1; k <= T_TO; k++) begin
      tick();
      if (k == T_TO - 1) chk("to_early", timeout, 0);
    end
    chk("to_fire", timeout, TO_EN);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("to_clear", timeout, 0);
    chk("to_popped", count, 0);

    // Random run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      enable   = ($urandom_range(0, 299) != 0);
      rxDone   = ($urandom_range(0, 2) == 0);
      rxData   = 8'($urandom);
      rxErr    = ($urandom_range(0, 19) == 0);
      clearErr = ($urandom_range(0, 149) == 0);
      outReady = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      model_step();
      tick();
      exp_v = {7'd0, (mq.size() > 0), m_head, 4'(mq.size()), m_ovr, 8'(m_err),
               (TO_EN && m_idle == T_TO)};
      chk($sformatf("rand%0d", c),
          {7'd0, outValid, outData, count, overrun, errCount, timeout}, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
